spi_master_core: RTL and testbench
==================================

# spi_master_core

Bit-serial SPI master engine for the AXI-Stream SPI peripheral. It consumes the clock-divider and CPOL/CPHA values held in the SPI register map, and takes transmit bytes on an AXI-Stream slave port. It runs one chip-select-framed full-duplex transfer per byte and returns the received byte on an AXI-Stream master port. It sits between the register/stream front end and the SPI pins.

## Interface

- DATA_WIDTH, 8, bits per transfer; equals the data field width of the TX/RX data registers.
- DIVIDER_WIDTH, 32, width of the clock-divider register value.

- clk_i  input  1  system clock.
- rstn_i  input  1  reset; one clock, reset synchronous to clk_i, active-low.
- clk_divider_i  input  DIVIDER_WIDTH  SCLK half-period in clk_i cycles; 0 treated as 1.
- cpol_i  input  1  SCLK idle level.
- cpha_i  input  1  0: sample on leading edge; 1: sample on trailing edge.
- s_axis_tdata_i  input  DATA_WIDTH  byte to transmit.
- s_axis_tvalid_i  input  1  TX byte valid.
- s_axis_tready_o  output  1  engine can accept a byte.
- m_axis_tdata_o  output  DATA_WIDTH  received byte.
- m_axis_tvalid_o  output  1  received byte valid.
- m_axis_tready_i  input  1  downstream accepts the received byte.
- spi_sclk_o  output  1  SPI clock.
- spi_cs_n_o  output  1  chip select, active-low.
- spi_mosi_o  output  1  serial data out.
- spi_miso_i  input  1  serial data in. Synchronised externally.
- busy_o  output  1  high in any state other than IDLE.

## Operation

- States: IDLE, SETUP, TRANSFER, HOLD.
- s_axis_tready_o = (state == IDLE) && !m_axis_tvalid_o && rstn_i. The one-entry RX register can therefore never overflow.
- IDLE → SETUP on an s_axis handshake:
  - latch tdata into the shift register;
  - latch the divider as D = max(clk_divider_i, 1);
  - latch cpol_i and cpha_i.
- Config inputs changing mid-transfer have no effect.
- SETUP:
  - spi_cs_n_o = 0 and spi_sclk_o = latched CPOL;
  - for CPHA=0, spi_mosi_o = MSB;
  - lasts D cycles, then → TRANSFER.
- TRANSFER: 2·DATA_WIDTH SCLK edges, one every D cycles; SCLK toggles on each edge.
  - CPHA=0: sample MISO on odd (leading) edges; shift MOSI to the next bit on even (trailing) edges, except the last edge.
  - CPHA=1: drive MOSI (MSB first) on leading edges; sample MISO on trailing edges.
  - Data order is MSB first in both directions.
  - After edge 2·DATA_WIDTH → HOLD. SCLK is back at CPOL.
- HOLD: lasts D cycles, then:
  - spi_cs_n_o = 1;
  - m_axis_tdata_o = shifted-in byte and m_axis_tvalid_o = 1;
  - → IDLE.
- m_axis_tvalid_o clears on the cycle after the m_axis handshake. No new transfer starts while it is set.
- Edge/half-period counter is DIVIDER_WIDTH bits and counts 0..D-1. It must not wrap for D = 2^DIVIDER_WIDTH-1.
- In IDLE, spi_sclk_o follows cpol_i, registered with one-cycle latency. spi_mosi_o holds its last value.

## Timing

- Reset values (while rstn_i low and on the first cycle after):
  - state IDLE;
  - spi_cs_n_o 1, spi_sclk_o 0, spi_mosi_o 0;
  - s_axis_tready_o 0 (during reset);
  - m_axis_tvalid_o 0, m_axis_tdata_o 0, busy_o 0.
- With the handshake in cycle 0:
  - cs_n falls and busy rises at cycle 1;
  - SCLK edge k occurs at cycle 1+k·D, for k = 1..2·DATA_WIDTH;
  - cs_n rises and m_axis_tvalid_o rises at cycle 1+(2·DATA_WIDTH+1)·D.
- MISO is sampled on the clk_i cycle in which the sampling SCLK edge is registered.
- Back-to-back transfers: if the RX byte is consumed on the cycle tvalid rises, the next handshake can occur the following cycle. cs_n is high for at least 1 cycle between frames.
- Reset mid-transfer:
  - next cycle cs_n = 1 and SCLK = 0;
  - the partial RX byte is discarded and m_axis_tvalid_o = 0.
- Simultaneous m_axis handshake and a pending s_axis_tvalid: tready rises the next cycle, never the same cycle.

## Test plan

- Mode 0, D=2, tx 0xA5, MISO slave returns 0x3C. Required:
  - MOSI bits 1,0,1,0,0,1,0,1 sampled on rising edges;
  - rx 0x3C;
  - tvalid 35 cycles after the handshake.
- All four CPOL/CPHA modes, D=3, tx 0x81 against a mode-matched loopback slave:
  - rx 0x81 each time;
  - idle SCLK level equals CPOL;
  - exactly 16 edges per frame.
- clk_divider_i=0 behaves identically to 1: edge spacing 1 cycle, tvalid 18 cycles after the handshake.
- RX backpressure: hold m_axis_tready_i=0 for 50 cycles with s_axis_tvalid high. Required:
  - tready stays 0 and there is no second frame;
  - after release, the next frame starts the cycle after tready rises.
- Change cpol_i and clk_divider_i mid-frame: the current frame keeps its latched mode and timing; the new values apply to the next frame.
- Assert rstn_i low at edge 7 of a frame:
  - cs_n=1, tvalid=0 next cycle;
  - a subsequent 0x5A transfer completes correctly.

Source files
------------

// File: rtl/spi_master_core.sv
// Bit-serial SPI master: one cs_n-framed full-duplex byte per s_axis beat; rx valid at 1+(2*DATA_WIDTH+1)*D cycles after the handshake.
// Backpressure: s_axis_tready is low while a frame runs or an unconsumed rx byte is held, so the rx register cannot overflow.
module spi_master_core #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIVIDER_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     cpol_i,
  input  logic                     cpha_i,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     spi_sclk_o,
  output logic                     spi_cs_n_o,
  output logic                     spi_mosi_o,
  input  logic                     spi_miso_i,
  output logic                     busy_o
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int EW    = $clog2(EDGES + 1);
  localparam logic [DIVIDER_WIDTH-1:0] DIV_ONE = DIVIDER_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [DIVIDER_WIDTH-1:0] div_q, cnt_q;
  logic                     cpha_q;
  logic [EW-1:0]            edge_q, edge_nxt;
  logic [DATA_WIDTH-1:0]    tx_sh_q, rx_sh_q, rx_dat_q;
  logic                     sclk_q, mosi_q, rx_vld_q;
  logic                     start, tick, edge_evt, last_edge, sample_edge, drive_edge, frame_done;

  assign s_axis_tready_o = (state_q == IDLE) && !rx_vld_q && rstn_i;
  assign start           = s_axis_tvalid_i && s_axis_tready_o;
  assign tick            = (cnt_q == div_q - DIV_ONE);
  assign edge_evt        = tick && ((state_q == SETUP) || (state_q == TRANSFER));
  assign edge_nxt        = edge_q + EW'(1);
  assign last_edge       = (edge_nxt == EW'(EDGES));
  // Odd edges are leading; CPHA=1 moves sampling to trailing edges.
  assign sample_edge     = edge_nxt[0] ^ cpha_q;
  assign drive_edge      = !sample_edge && !last_edge;

  assign m_axis_tdata_o  = rx_dat_q;
  assign m_axis_tvalid_o = rx_vld_q;
  assign spi_sclk_o      = sclk_q;
  assign spi_mosi_o      = mosi_q;

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    busy_o     = (state_q != IDLE);
    spi_cs_n_o = (state_q == IDLE);
    case (state_q)
      IDLE:     if (start) state_d = SETUP;
      SETUP:    if (tick) state_d = TRANSFER;
      TRANSFER: if (tick && last_edge) state_d = HOLD;
      HOLD: begin
        if (tick) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      div_q    <= DIV_ONE;
      cnt_q    <= '0;
      cpha_q   <= 1'b0;
      edge_q   <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      rx_dat_q <= '0;
      rx_vld_q <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) || tick) cnt_q <= '0;
      else                           cnt_q <= cnt_q + DIV_ONE;

      if (rx_vld_q && m_axis_tready_i) rx_vld_q <= 1'b0;

      // Idle tracking also captures CPOL on the handshake cycle; it then holds through SETUP.
      if (state_q == IDLE) sclk_q <= cpol_i;

      if (start) begin
        div_q  <= (clk_divider_i == '0) ? DIV_ONE : clk_divider_i;
        cpha_q <= cpha_i;
        edge_q <= '0;
        if (cpha_i) begin
          tx_sh_q <= s_axis_tdata_i;
        end else begin
          mosi_q  <= s_axis_tdata_i[DATA_WIDTH-1];
          tx_sh_q <= s_axis_tdata_i << 1;
        end
      end

      if (edge_evt) begin
        edge_q <= edge_nxt;
        sclk_q <= ~sclk_q;
        if (sample_edge) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], spi_miso_i};
        if (drive_edge) begin
          mosi_q  <= tx_sh_q[DATA_WIDTH-1];
          tx_sh_q <= tx_sh_q << 1;
        end
      end

      if (frame_done) begin
        rx_dat_q <= rx_sh_q;
        rx_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: pin-level SPI slave model plus frame-level timing expectations.
module tb_spi_master_core;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [31:0]   clk_divider_i;
  logic          cpol_i, cpha_i;
  logic [DW-1:0] s_axis_tdata_i;
  logic          s_axis_tvalid_i, s_axis_tready_o;
  logic [DW-1:0] m_axis_tdata_o;
  logic          m_axis_tvalid_o, m_axis_tready_i;
  logic          spi_sclk_o, spi_cs_n_o, spi_mosi_o, spi_miso_i, busy_o;

  spi_master_core dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clk_divider_i(clk_divider_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tready_o(s_axis_tready_o),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tready_i(m_axis_tready_i),
    .spi_sclk_o(spi_sclk_o), .spi_cs_n_o(spi_cs_n_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pin-level slave: mode comes from what the frame was started with.
  logic          m_cpol = 1'b0, m_cpha = 1'b0;
  logic [DW-1:0] sl_tx = '0, sl_rx;
  int            sl_bit, sl_edges, cs_falls;
  int            edge_q[$];
  logic          prev_sclk, prev_cs;

  initial begin
    prev_sclk = 1'b0; prev_cs = 1'b1; spi_miso_i = 1'b0;
    sl_edges = 0; cs_falls = 0; sl_bit = 0; sl_rx = '0;
    forever begin
      @(negedge clk_i);
      if (prev_cs && !spi_cs_n_o) begin
        cs_falls++;
        sl_edges = 0; sl_rx = '0; edge_q.delete();
        sl_bit = DW - 1;
        if (!m_cpha) begin spi_miso_i = sl_tx[sl_bit]; sl_bit--; end
      end else if (!spi_cs_n_o && (spi_sclk_o != prev_sclk)) begin
        sl_edges++;
        edge_q.push_back(cyc);
        if ((spi_sclk_o != m_cpol) ^ m_cpha) sl_rx = {sl_rx[DW-2:0], spi_mosi_o};
        else if (sl_bit >= 0) begin spi_miso_i = sl_tx[sl_bit]; sl_bit--; end
      end
      prev_sclk = spi_sclk_o;
      prev_cs   = spi_cs_n_o;
    end
  end

  int last_hs;

  // Call at a negedge. Runs one frame and checks it against the expected timeline.
  task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] slv,
                           input logic pol, input logic pha, input int div, input bit chg);
    int d, hs, tv, errs;
    d = (div == 0) ? 1 : div;
    cpol_i = pol; cpha_i = pha; clk_divider_i = 32'(div);
    s_axis_tdata_i = tx; s_axis_tvalid_i = 1'b1;
    m_cpol = pol; m_cpha = pha; sl_tx = slv;
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      if (s_axis_tready_o) begin hs = cyc; break; end
      @(negedge clk_i);
    end
    if (hs < 0) begin
      chk("hs_timeout", 0, 1);
      s_axis_tvalid_i = 1'b0;
      return;
    end
    last_hs = hs;
    @(negedge clk_i);
    s_axis_tvalid_i = 1'b0;
    chk("cs_low", 32'(spi_cs_n_o), 0);
    chk("busy", 32'(busy_o), 1);
    tv = -1;
    for (int i = 0; i < 20 * d + 40; i++) begin
      if (chg && cyc == hs + 5) begin cpol_i = ~pol; clk_divider_i = 32'd1; end
      if (m_axis_tvalid_o) begin tv = cyc; break; end
      @(negedge clk_i);
    end
    if (tv < 0) begin
      chk("tvalid_timeout", 0, 1);
      return;
    end
    chk("latency", tv - hs, 1 + (2 * DW + 1) * d);
    chk("rx_byte", 32'(m_axis_tdata_o), 32'(slv));
    chk("mosi_byte", 32'(sl_rx), 32'(tx));
    chk("edges", sl_edges, 2 * DW);
    errs = 0;
    for (int k = 1; k <= edge_q.size(); k++)
      if (edge_q[k-1] != hs + 1 + k * d) errs++;
    chk("edge_time", errs, 0);
    chk("cs_end", 32'(spi_cs_n_o), 1);
    chk("sclk_end", 32'(spi_sclk_o), 32'(pol));
    @(negedge clk_i);
    chk("sclk_idle", 32'(spi_sclk_o), 32'(cpol_i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, falls0, r, hs;
    logic [DW-1:0] tx, slv;
    rstn_i = 1'b0; clk_divider_i = 32'd1; cpol_i = 1'b0; cpha_i = 1'b0;
    s_axis_tdata_i = '0; s_axis_tvalid_i = 1'b0; m_axis_tready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_tready", 32'(s_axis_tready_o), 0);
    chk("rst_cs", 32'(spi_cs_n_o), 1);
    chk("rst_sclk", 32'(spi_sclk_o), 0);
    chk("rst_mosi", 32'(spi_mosi_o), 0);
    chk("rst_tvalid", 32'(m_axis_tvalid_o), 0);
    chk("rst_tdata", 32'(m_axis_tdata_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_cs", 32'(spi_cs_n_o), 1);
    chk("post_rst_sclk", 32'(spi_sclk_o), 0);

    run_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 2, 1'b0);

    for (int m = 0; m < 4; m++)
      run_frame(8'h81, 8'h81, m[1], m[0], 3, 1'b0);

    run_frame(8'h4D, 8'hB2, 1'b0, 1'b0, 0, 1'b0);
    run_frame(8'h17, 8'hE8, 1'b1, 1'b1, 1, 1'b0);

    // rx backpressure
    m_axis_tready_i = 1'b0;
    run_frame(8'hC3, 8'h5E, 1'b0, 1'b0, 1, 1'b0);
    s_axis_tdata_i = 8'h96; s_axis_tvalid_i = 1'b1;
    falls0 = cs_falls; bad = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (s_axis_tready_o) bad++;
    end
    chk("bp_tready", bad, 0);
    chk("bp_no_frame", cs_falls - falls0, 0);
    chk("bp_hold_vld", 32'(m_axis_tvalid_o), 1);
    chk("bp_hold_dat", 32'(m_axis_tdata_o), 32'h5E);
    r = cyc;
    m_axis_tready_i = 1'b1;
    run_frame(8'h96, 8'h69, 1'b0, 1'b0, 1, 1'b0);
    chk("bp_restart", last_hs, r + 1);

    // config change mid-frame, new values on the next frame
    run_frame(8'h3E, 8'hC1, 1'b0, 1'b1, 4, 1'b1);
    run_frame(8'h77, 8'h12, 1'b1, 1'b1, 1, 1'b0);

    // reset around edge 7
    cpol_i = 1'b0; cpha_i = 1'b0; clk_divider_i = 32'd3;
    m_cpol = 1'b0; m_cpha = 1'b0; sl_tx = 8'hFF;
    s_axis_tdata_i = 8'hE7; s_axis_tvalid_i = 1'b1;
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      if (s_axis_tready_o) begin hs = cyc; break; end
      @(negedge clk_i);
    end
    chk("abort_hs", 32'(hs >= 0), 1);
    @(negedge clk_i);
    s_axis_tvalid_i = 1'b0;
    bad = 1;
    for (int i = 0; i < 100; i++) begin
      if (sl_edges == 7) begin bad = 0; break; end
      @(negedge clk_i);
    end
    chk("abort_edge7", bad, 0);
    rstn_i = 1'b0;
    @(negedge clk_i);
    chk("abort_cs", 32'(spi_cs_n_o), 1);
    chk("abort_sclk", 32'(spi_sclk_o), 0);
    chk("abort_tvalid", 32'(m_axis_tvalid_o), 0);
    chk("abort_tready", 32'(s_axis_tready_o), 0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("abort_no_rx", 32'(m_axis_tvalid_o), 0);
    run_frame(8'h5A, 8'hA6, 1'b0, 1'b0, 2, 1'b0);

    for (int n = 0; n < 8; n++) begin
      tx  = 8'($urandom);
      slv = 8'($urandom);
      run_frame(tx, slv, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
